fetch_unit: RTL
===============

Name: fetch_unit

Overview:
- Instruction fetch stage that sits directly upstream of the program ROM and owns the program counter.
- Drives the ROM address, captures the ROM's combinational opcode/operand into an instruction register, and presents them to the decode/execute stage over a valid/ready handshake.
- Handles PC increment with wrap, redirects (jumps) from execute, and a halt opcode.

Parameters:
- ADDR_W, 4, PC / ROM address width
- OPC_W, 4, opcode width
- OPR_W, 4, operand width
- HALT_OPC, 4'hF, opcode that stops fetching after it is issued
- RESET_PC, 4'h0, PC value loaded on reset

Ports:
- clk  in  1  clock, rising-edge
- rst_n  in  1  asynchronous active-low reset
- pc_addr  out  ADDR_W  current PC, wired to ROM address input
- rom_opcode  in  OPC_W  opcode from ROM at pc_addr (combinational)
- rom_operand  in  OPR_W  operand from ROM at pc_addr (combinational)
- ir_valid  out  1  instruction register holds an unconsumed instruction
- ir_ready  in  1  downstream accepts the instruction this cycle
- ir_opcode  out  OPC_W  latched opcode
- ir_operand  out  OPR_W  latched operand
- ir_pc  out  ADDR_W  address the latched instruction was fetched from
- jmp_en  in  1  redirect request from execute
- jmp_addr  in  ADDR_W  redirect target
- halt  out  1  fetch stopped on HALT_OPC

Behaviour:
- Clocking and reset:
  - One clock; reset is asynchronous and active-low.
  - Outputs while reset is asserted or immediately after release: pc_addr=RESET_PC, ir_valid=0, ir_opcode=0, ir_operand=0, ir_pc=0, halt=0, state=FETCH.
  - Reset asserted mid-operation discards the IR contents immediately, without waiting for a clock edge.
- States: FETCH, ISSUE, HALTED (encoded as 2 bits).
- FETCH:
  - pc_addr is stable all cycle.
  - At the edge: ir_opcode<=rom_opcode, ir_operand<=rom_operand, ir_pc<=pc, ir_valid<=1, go to ISSUE.
  - ROM is sampled in the same cycle it is addressed, so the first ir_valid is high one edge after reset release.
- ISSUE:
  - IR, ir_valid and pc are held stable while ir_ready=0. No input changes them except jmp_en.
  - On handshake (ir_valid and ir_ready):
    - If ir_opcode==HALT_OPC: ir_valid<=0, halt<=1, go to HALTED; pc unchanged.
    - Otherwise: pc<=pc+1, go to FETCH, ir_valid<=0.
- HALTED:
  - ir_valid=0, halt=1, pc held, rom inputs ignored.
  - Exit only via jmp_en or reset.
- Redirect (jmp_en=1) has priority in any state:
  - pc<=jmp_addr, ir_valid<=0, halt<=0, go to FETCH.
  - If a handshake occurs in the same cycle, that instruction counts as consumed and the jump still wins; no increment is applied.
  - In FETCH, the capture is suppressed: the IR does not load that cycle.
- Arithmetic: pc+1 is modulo 2^ADDR_W, so 4'hF wraps to 4'h0 with no flag.
- Throughput: with ir_ready tied high, one instruction per 2 cycles. Each stall cycle adds one cycle.
- The HALT instruction itself is issued (presented with ir_valid=1) before halt asserts; halt rises on the edge that completes its handshake.
- ir_pc is required by execute to compute relative targets; it always equals the pc value at capture.

Decomposition:
- Shared package cpu_pkg holds:
  - ADDR_W/OPC_W/OPR_W localparams
  - typedef fetch_state_t enum {FETCH, ISSUE, HALTED}
  - HALT_OPC constant, which the decoder also uses
- No sub-module. The PC register, IR and FSM stay in one module; the ROM remains a separate instance wired at the top level.

Test Plan:
- Reset/first fetch: hold rst_n=0 for 3 cycles with ROM[0]=8'h3A; release with ir_ready=1 -> during reset pc_addr=0, ir_valid=0, halt=0; after the first edge ir_valid=1, ir_opcode=4'h3, ir_operand=4'hA, ir_pc=0; after the next edge pc_addr=1.
- Backpressure: hold ir_ready=0 for 5 cycles with ir_valid=1 at pc=2 -> IR, ir_pc=2 and pc_addr=2 remain constant; when ir_ready=1 the handshake completes and pc_addr=3 one cycle later.
- Wrap-around: jump to 4'hF with ROM[F] non-halt and ir_ready=1 -> after the issue of pc=F, pc_addr=4'h0 and the next ir_pc=0.
- Halt: ROM[1]=8'hF0 -> the instruction at pc=1 is issued with ir_opcode=F; after the handshake halt=1, ir_valid=0, pc_addr stays 1 for 10 cycles; then jmp_en=1 with jmp_addr=7 -> halt=0, pc_addr=7, next ir_pc=7.
- Jump collides with handshake: in ISSUE at pc=4, drive ir_ready=1 and jmp_en=1 (jmp_addr=A) in the same cycle -> pc_addr=A, not 5; next ir_pc=A; no duplicate issue of pc=4.
- Async reset mid-ISSUE: deassert rst_n between clock edges while ir_valid=1 -> ir_valid=0 and pc_addr=0 immediately, before the next clk edge.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the fetch stage and by the decoder.
//   ADDR_W / OPC_W / OPR_W : PC, opcode and operand widths
//   HALT_OPC               : opcode that stops fetching once it has been issued
//   RESET_PC               : program counter value after reset
//   fetch_state_t          : fetch FSM state encoding (2 bits)
//   pc_inc()               : next sequential PC, wrapping modulo 2^ADDR_W
package cpu_pkg;

  localparam int ADDR_W = 4;
  localparam int OPC_W  = 4;
  localparam int OPR_W  = 4;

  localparam logic [OPC_W-1:0]  HALT_OPC = 4'hF;
  localparam logic [ADDR_W-1:0] RESET_PC = 4'h0;

  typedef enum logic [1:0] {
    FETCH  = 2'b00,
    ISSUE  = 2'b01,
    HALTED = 2'b10
  } fetch_state_t;

  // Sequential successor of a PC; the carry out of the top bit is dropped,
  // so the last address wraps to zero with no flag.
  function automatic logic [ADDR_W-1:0] pc_inc(input logic [ADDR_W-1:0] pc);
    return pc + {{(ADDR_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch stage. Owns the program counter, addresses the program
// ROM, latches the ROM's combinational opcode/operand into an instruction
// register and hands it to decode/execute over a valid/ready handshake.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   pc_addr      current PC, drives the ROM address
//   rom_opcode   opcode read from ROM at pc_addr (combinational)
//   rom_operand  operand read from ROM at pc_addr (combinational)
//   ir_valid     instruction register holds an unconsumed instruction
//   ir_ready     downstream accepts the instruction this cycle
//   ir_opcode    latched opcode
//   ir_operand   latched operand
//   ir_pc        address the latched instruction was fetched from
//   jmp_en       redirect request from execute
//   jmp_addr     redirect target
//   halt         fetch has stopped on HALT_OPC
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [OPC_W-1:0]  HALT_CODE = HALT_OPC,
  parameter logic [ADDR_W-1:0] RESET_ADDR = RESET_PC
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] pc_addr,
  input  logic [OPC_W-1:0]  rom_opcode,
  input  logic [OPR_W-1:0]  rom_operand,
  output logic              ir_valid,
  input  logic              ir_ready,
  output logic [OPC_W-1:0]  ir_opcode,
  output logic [OPR_W-1:0]  ir_operand,
  output logic [ADDR_W-1:0] ir_pc,
  input  logic              jmp_en,
  input  logic [ADDR_W-1:0] jmp_addr,
  output logic              halt
);

  fetch_state_t      state_r;
  logic [ADDR_W-1:0] pc_r;
  logic              ir_valid_r;
  logic [OPC_W-1:0]  ir_opcode_r;
  logic [OPR_W-1:0]  ir_operand_r;
  logic [ADDR_W-1:0] ir_pc_r;
  logic              halt_r;

  logic handshake_s;
  assign handshake_s = ir_valid_r & ir_ready;

  // Fetch FSM together with the PC, instruction register and status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= FETCH;
      pc_r         <= RESET_ADDR;
      ir_valid_r   <= 1'b0;
      ir_opcode_r  <= {OPC_W{1'b0}};
      ir_operand_r <= {OPR_W{1'b0}};
      ir_pc_r      <= {ADDR_W{1'b0}};
      halt_r       <= 1'b0;
    end else if (jmp_en) begin
      // A redirect beats everything: a handshake in the same cycle still
      // consumes the instruction, but no increment is applied and a pending
      // FETCH capture is dropped.
      state_r    <= FETCH;
      pc_r       <= jmp_addr;
      ir_valid_r <= 1'b0;
      halt_r     <= 1'b0;
    end else begin
      case (state_r)
        FETCH: begin
          // The ROM is combinational on pc_addr, so it is sampled in the
          // same cycle it is addressed.
          ir_opcode_r  <= rom_opcode;
          ir_operand_r <= rom_operand;
          ir_pc_r      <= pc_r;
          ir_valid_r   <= 1'b1;
          state_r      <= ISSUE;
        end
        ISSUE: begin
          if (handshake_s) begin
            ir_valid_r <= 1'b0;
            if (ir_opcode_r == HALT_CODE) begin
              // The HALT itself has now been issued; stop with pc unchanged.
              halt_r  <= 1'b1;
              state_r <= HALTED;
            end else begin
              pc_r    <= pc_inc(pc_r);
              state_r <= FETCH;
            end
          end else begin
            state_r <= ISSUE;
          end
        end
        HALTED: begin
          // Only a redirect or reset leaves this state.
          state_r    <= HALTED;
          ir_valid_r <= 1'b0;
          halt_r     <= 1'b1;
        end
        default: begin
          state_r    <= FETCH;
          ir_valid_r <= 1'b0;
          halt_r     <= 1'b0;
        end
      endcase
    end
  end

  assign pc_addr    = pc_r;
  assign ir_valid   = ir_valid_r;
  assign ir_opcode  = ir_opcode_r;
  assign ir_operand = ir_operand_r;
  assign ir_pc      = ir_pc_r;
  assign halt       = halt_r;

endmodule
